// File: rtl/esc_dispatch_ctrl.sv
// ESC (D8-DF) dispatcher: queues CPU opcode/ModR/M/EA triples, runs each through
// the external registered decoder and issues one FPU command, then waits for done.
module esc_dispatch_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int ADDR_WIDTH     = 20,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cpu_esc_valid,
   input  logic [7:0]                  cpu_opcode,
   input  logic [7:0]                  cpu_modrm,
   input  logic [ADDR_WIDTH-1:0]       cpu_ea,
   output logic                        cpu_esc_ready,
   output logic                        cpu_non_esc,
   output logic [7:0]                  dec_opcode,
   output logic [7:0]                  dec_modrm,
   output logic                        dec_valid,
   input  logic                        dec_is_esc,
   input  logic [2:0]                  dec_esc_index,
   input  logic [2:0]                  dec_fpu_opcode,
   input  logic [2:0]                  dec_stack_index,
   input  logic                        dec_has_memory_op,
   output logic                        fpu_cmd_valid,
   input  logic                        fpu_cmd_ready,
   output logic [5:0]                  fpu_cmd_op,
   output logic [2:0]                  fpu_cmd_stack,
   output logic                        fpu_cmd_has_mem,
   output logic [ADDR_WIDTH-1:0]       fpu_cmd_ea,
   input  logic                        fpu_done,
   output logic [$clog2(FIFO_DEPTH):0] queue_count,
   output logic                        ctrl_idle,
   output logic                        timeout_err,
   input  logic                        err_clear
);

   localparam int                PTR_W      = $clog2(FIFO_DEPTH);
   localparam int                CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]       WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_LATCH,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t                  r_state;
   logic [7:0]              r_fifo_op    [FIFO_DEPTH];
   logic [7:0]              r_fifo_modrm [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_fifo_ea    [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_non_esc;
   logic [7:0]              r_dec_opcode;
   logic [7:0]              r_dec_modrm;
   logic                    r_dec_valid;
   logic [ADDR_WIDTH-1:0]   r_ea;
   logic                    r_cmd_valid;
   logic [5:0]              r_cmd_op;
   logic [2:0]              r_cmd_stack;
   logic                    r_cmd_has_mem;
   logic [ADDR_WIDTH-1:0]   r_cmd_ea;
   logic [15:0]             r_wait_cnt;
   logic                    r_timeout_err;

   logic w_full;
   logic w_empty;
   logic w_accept;
   logic w_is_esc;
   logic w_push;
   logic w_pop;
   logic w_timeout;

   assign w_full    = (r_count == FULL_COUNT);
   assign w_empty   = (r_count == '0);
   assign w_accept  = cpu_esc_valid && !w_full;
   assign w_is_esc  = (cpu_opcode[7:3] == 5'b11011);
   assign w_push    = w_accept && w_is_esc;
   assign w_pop     = (r_state == S_IDLE) && !w_empty;
   // Done on the last counted cycle takes priority over the abort.
   assign w_timeout = (r_state == S_WAIT_DONE) && !fpu_done && (r_wait_cnt == WAIT_LAST);

   // NOTE: queue storage has no reset; occupancy is tracked by the pointers and
   // count, so stale entries are never read and the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_op[r_wr_ptr]    <= cpu_opcode;
         r_fifo_modrm[r_wr_ptr] <= cpu_modrm;
         r_fifo_ea[r_wr_ptr]    <= cpu_ea;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_non_esc <= 1'b0;
      end else begin
         r_non_esc <= w_accept && !w_is_esc;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_dec_opcode  <= '0;
         r_dec_modrm   <= '0;
         r_dec_valid   <= 1'b0;
         r_ea          <= '0;
         r_cmd_valid   <= 1'b0;
         r_cmd_op      <= '0;
         r_cmd_stack   <= '0;
         r_cmd_has_mem <= 1'b0;
         r_cmd_ea      <= '0;
         r_wait_cnt    <= '0;
      end else begin
         r_dec_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_dec_opcode <= r_fifo_op[r_rd_ptr];
                  r_dec_modrm  <= r_fifo_modrm[r_rd_ptr];
                  r_ea         <= r_fifo_ea[r_rd_ptr];
                  r_dec_valid  <= 1'b1;
                  r_state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               if (!dec_is_esc) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cmd_op      <= {dec_esc_index, dec_fpu_opcode};
                  r_cmd_stack   <= dec_stack_index;
                  r_cmd_has_mem <= dec_has_memory_op;
                  r_cmd_ea      <= dec_has_memory_op ? r_ea : '0;
                  r_cmd_valid   <= 1'b1;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (fpu_cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_wait_cnt  <= '0;
                  r_state     <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (fpu_done || w_timeout) r_state <= S_IDLE;
               else                       r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
      else if (err_clear) r_timeout_err <= 1'b0;
   end

   assign cpu_esc_ready   = !w_full;
   assign cpu_non_esc     = r_non_esc;
   assign dec_opcode      = r_dec_opcode;
   assign dec_modrm       = r_dec_modrm;
   assign dec_valid       = r_dec_valid;
   assign fpu_cmd_valid   = r_cmd_valid;
   assign fpu_cmd_op      = r_cmd_op;
   assign fpu_cmd_stack   = r_cmd_stack;
   assign fpu_cmd_has_mem = r_cmd_has_mem;
   assign fpu_cmd_ea      = r_cmd_ea;
   assign queue_count     = r_count;
   assign ctrl_idle       = (r_state == S_IDLE) && w_empty;
   assign timeout_err     = r_timeout_err;

endmodule

// File: doc/esc_dispatch_ctrl.md
Name: esc_dispatch_ctrl

Overview:
Sequences ESC (D8-DF) instructions from the CPU to the 8087 FPU. Queues CPU-issued opcode/ModR/M/effective-address triples in a small FIFO and drives the ESC decoder one entry at a time, using its registered outputs. Issues one command per instruction to the FPU with a valid/ready handshake, then waits for completion under a timeout. Sits between the CPU execution unit and the FPU core, and owns the decoder's valid strobe.

Parameters:
FIFO_DEPTH, 4, queue entries; power of two, minimum 2.
ADDR_WIDTH, 20, width of the effective address.
TIMEOUT_CYCLES, 1024, maximum WAIT_DONE cycles before abort; 16-bit counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_esc_valid  in  1  CPU presents an instruction
cpu_opcode  in  8  instruction opcode
cpu_modrm  in  8  ModR/M byte
cpu_ea  in  ADDR_WIDTH  effective address; don't-care when mod=11
cpu_esc_ready  out  1  instruction accepted this cycle when high with cpu_esc_valid
cpu_non_esc  out  1  one-cycle pulse: a non-ESC opcode was consumed and dropped
dec_opcode  out  8  decoder opcode input
dec_modrm  out  8  decoder ModR/M input
dec_valid  out  1  decoder sample strobe
dec_is_esc  in  1  decoder result (registered, 1-cycle latency)
dec_esc_index  in  3  decoder result
dec_fpu_opcode  in  3  decoder result
dec_stack_index  in  3  decoder result
dec_has_memory_op  in  1  decoder result
fpu_cmd_valid  out  1  command valid
fpu_cmd_ready  in  1  FPU accepts command
fpu_cmd_op  out  6  {esc_index, fpu_opcode}
fpu_cmd_stack  out  3  ST(i)
fpu_cmd_has_mem  out  1  memory operand present
fpu_cmd_ea  out  ADDR_WIDTH  effective address
fpu_done  in  1  completion pulse
queue_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
ctrl_idle  out  1  high when in IDLE with an empty queue
timeout_err  out  1  sticky abort flag
err_clear  in  1  clears timeout_err

Behaviour:
- Reset (async assert, sync-released state): FSM=IDLE, FIFO empty, queue_count=0, timeout counter=0. Outputs: cpu_esc_ready=1, cpu_non_esc=0, dec_valid=0, fpu_cmd_valid=0, dec_opcode/dec_modrm=0, fpu_cmd_* all 0, ctrl_idle=1, timeout_err=0. Reset mid-operation drops the queue and any in-flight command.
- Intake:
  - cpu_esc_ready = !full.
  - On valid&&ready with opcode[7:3]==11011: push {opcode, modrm, ea}.
  - On valid&&ready otherwise: no push; cpu_non_esc=1 the next cycle.
  - When full, ready=0 and the input is held by the CPU.
- Simultaneous push and pop: both take effect; queue_count is unchanged. A push into a full FIFO cannot occur. A pop from an empty FIFO never occurs.
- FSM:
  - IDLE: if the queue is non-empty, pop the head into the dec_opcode/dec_modrm/ea registers and go to DECODE. A push into an empty queue at cycle T gives DECODE at T+2.
  - DECODE: dec_valid=1 for exactly one cycle; dec_opcode/dec_modrm are held stable from DECODE through LATCH. Next state: LATCH.
  - LATCH: decoder outputs are valid. If dec_is_esc=0, drop the entry and go to IDLE (defensive). Otherwise register fpu_cmd_op/stack/has_mem, set fpu_cmd_ea to the held ea (0 if !has_memory_op), and go to ISSUE.
  - ISSUE: fpu_cmd_valid=1; fields are held stable until fpu_cmd_ready. On the ready cycle, go to WAIT_DONE with counter=0. fpu_cmd_valid drops the following cycle.
  - WAIT_DONE: counter increments each cycle. fpu_done is sampled only in this state.
    - fpu_done → IDLE.
    - Counter reaching TIMEOUT_CYCLES-1 without done → set timeout_err, go to IDLE, discard the command.
    - fpu_done on the final counter cycle: done wins, no error.
- Back-to-back throughput: IDLE→DECODE→LATCH→ISSUE→WAIT_DONE→IDLE, minimum 5 cycles per instruction with immediate ready and done.
- timeout_err: sticky. err_clear clears it; a set and a clear in the same cycle leaves it set.
- ctrl_idle = (state==IDLE) && (queue_count==0).

Test Plan:
- Reset, then push D9/C1 (FLD ST(1)) with ready and done tied high → dec_valid at T+2. fpu_cmd_valid at T+4 with op=6'b001_000, stack=1, has_mem=0, ea=0. ctrl_idle returns high.
- Push DD/06 with ea=0x12345 → fpu_cmd_has_mem=1, fpu_cmd_ea=0x12345, op=6'b101_000.
- Push opcode 0x90 → not enqueued, cpu_non_esc pulses one cycle, queue_count stays 0.
- Hold fpu_cmd_ready=0 and push 5 ESC ops with FIFO_DEPTH=4 → 1 op in ISSUE plus 4 queued, cpu_esc_ready=0 while full. Fields stay stable under backpressure. Releasing ready drains the ops in order.
- Push in the same cycle as an IDLE pop → queue_count unchanged.
- Never assert fpu_done → timeout_err=1 after 1024 WAIT_DONE cycles and the next entry dispatches. err_clear clears the flag. fpu_done on cycle 1023 → no error.
- Assert reset_n low asynchronously during ISSUE with 3 entries queued → fpu_cmd_valid=0 immediately, queue_count=0, ctrl_idle=1.
